// File: rtl/stream_demux_pkg.sv
// Shared defaults and helpers for the stream demultiplexer.
//   DEFAULT_WIDTH  : data word width
//   DEFAULT_N_OUT  : number of output channels
//   DEFAULT_DROP_W : drop counter width
//   clog2()        : ceiling log2, used to size the channel select
package stream_demux_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 8;
  localparam int unsigned DEFAULT_N_OUT  = 4;
  localparam int unsigned DEFAULT_DROP_W = 8;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slot with valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   load      : write in_data into the slot this edge (caller checks free)
//   in_data   : word to store
//   out_valid : slot holds a word
//   out_ready : consumer takes the word this cycle
//   out_data  : stored word; retains its value after draining
//   free      : slot can be loaded this cycle (empty or draining)
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  // Draining and refilling on the same edge keeps full throughput.
  assign free = !out_valid || out_ready;

  // Full flag: load wins over drain so a refill keeps the slot valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Data holds its last value when the slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// 1-to-N registered stream demultiplexer with broadcast and drop counting.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input word valid
//   in_ready   : input can be accepted (combinational from out_ready/sel/bcast)
//   in_data    : input word
//   sel        : destination channel, used on acceptance
//   bcast      : deliver to every channel, used on acceptance
//   out_valid  : per-channel slot full
//   out_ready  : per-channel consumer ready
//   out_data   : channel i on bits [i*WIDTH +: WIDTH]
//   drop_pulse : one cycle after an out-of-range word is discarded
//   drop_cnt   : saturating count of discarded words
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned N_OUT  = DEFAULT_N_OUT,
  parameter int unsigned SEL_W  = clog2(N_OUT),
  parameter int unsigned DROP_W = DEFAULT_DROP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   bcast,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   drop_pulse,
  output logic [DROP_W-1:0]      drop_cnt
);

  // One extra bit so the range compare never degenerates to a constant.
  localparam int unsigned SEL_X = SEL_W + 1;

  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] sel_hot;
  logic [N_OUT-1:0] load;
  logic             sel_free;
  logic             in_range;
  logic             accept;
  logic             drop;

  assign in_range = {1'b0, sel} < SEL_X'(N_OUT);

  // Select decode; never indexes free[] with an out-of-range select.
  always_comb begin
    sel_hot  = '0;
    sel_free = 1'b0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hot[i] = 1'b1;
        sel_free   = free[i];
      end
    end
  end

  // Out-of-range words are always accepted so they can be discarded.
  always_comb begin
    in_ready = 1'b1;
    if (bcast) begin
      in_ready = &free;
    end else if (in_range) begin
      in_ready = sel_free;
    end
  end

  assign accept = in_valid && in_ready;
  assign load   = accept ? (bcast ? {N_OUT{1'b1}} : sel_hot) : '0;
  assign drop   = accept && !bcast && !in_range;

  for (genvar g = 0; g < int'(N_OUT); g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[g]),
      .in_data  (in_data),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g*WIDTH +: WIDTH]),
      .free     (free[g])
    );
  end

  // Drop pulse and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel instance driven from a
// vector table and a 3-channel instance for out-of-range drop handling.
module tb_stream_demux_n;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst4, vld4, bc4, rdy4, dp4;
  logic [7:0]  data4, cnt4;
  logic [1:0]  sel4;
  logic [3:0]  ov4, ordy4;
  logic [31:0] od4;

  stream_demux_n #(.WIDTH(8), .N_OUT(4), .DROP_W(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst4),
    .in_valid  (vld4),
    .in_ready  (rdy4),
    .in_data   (data4),
    .sel       (sel4),
    .bcast     (bc4),
    .out_valid (ov4),
    .out_ready (ordy4),
    .out_data  (od4),
    .drop_pulse(dp4),
    .drop_cnt  (cnt4)
  );

  // 3-channel instance (select value 3 is out of range)
  logic        rst3, vld3, bc3, rdy3, dp3;
  logic [7:0]  data3, cnt3;
  logic [1:0]  sel3;
  logic [2:0]  ov3, ordy3;
  logic [23:0] od3;

  stream_demux_n #(.WIDTH(8), .N_OUT(3), .DROP_W(8)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .in_valid  (vld3),
    .in_ready  (rdy3),
    .in_data   (data3),
    .sel       (sel3),
    .bcast     (bc3),
    .out_valid (ov3),
    .out_ready (ordy3),
    .out_data  (od3),
    .drop_pulse(dp3),
    .drop_cnt  (cnt3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic [7:0]  data;
    logic [1:0]  sel;
    logic        bc;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [31:0] e_od;
    logic        e_dp;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic [1:0] s,
                     input logic b, input logic [3:0] o, input logic er, input logic [3:0] eov,
                     input logic [31:0] eod);
    vec_t t;
    t = '{rst: r, vld: v, data: d, sel: s, bc: b, ordy: o, e_rdy: er, e_ov: eov,
          e_od: eod, e_dp: 1'b0, e_cnt: 8'd0};
    vq.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic v, input logic [7:0] d, input logic [1:0] s,
                        input logic b, input logic [2:0] o);
    vld3 = v; data3 = d; sel3 = s; bc3 = b; ordy3 = o;
  endtask

  initial begin
    rst4 = 1'b1; vld4 = 1'b0; data4 = '0; sel4 = '0; bc4 = 1'b0; ordy4 = '0;
    rst3 = 1'b1; vld3 = 1'b0; data3 = '0; sel3 = '0; bc3 = 1'b0; ordy3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("reset_ov", 64'(ov4), 64'h0);
    chk("reset_od", 64'(od4), 64'h0);
    chk("reset_cnt", 64'(cnt4), 64'h0);
    chk("reset_dp", 64'(dp4), 64'h0);
    chk("reset_rdy", 64'(rdy4), 64'h1);
    chk("reset3_ov", 64'(ov3), 64'h0);

    // rst vld data sel bc ordy | rdy ov od
    // back-to-back one word per channel, all consumers ready
    add(0, 1, 8'hA0, 0, 0, 4'b1111, 1, 4'b0001, 32'h000000A0);
    add(0, 1, 8'hA1, 1, 0, 4'b1111, 1, 4'b0010, 32'h0000A1A0);
    add(0, 1, 8'hA2, 2, 0, 4'b1111, 1, 4'b0100, 32'h00A2A1A0);
    add(0, 1, 8'hA3, 3, 0, 4'b1111, 1, 4'b1000, 32'hA3A2A1A0);
    add(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'hA3A2A1A0);
    // channel 2 stalled; other channels keep flowing; drain+refill
    add(0, 1, 8'h55, 2, 0, 4'b1011, 1, 4'b0100, 32'hA355A1A0);
    add(0, 1, 8'h66, 2, 0, 4'b1011, 0, 4'b0100, 32'hA355A1A0);
    add(0, 1, 8'h77, 1, 0, 4'b1011, 1, 4'b0110, 32'hA35577A0);
    add(0, 1, 8'h66, 2, 0, 4'b1111, 1, 4'b0100, 32'hA36677A0);
    add(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'hA36677A0);
    // broadcast blocked by one full slot, then released
    add(0, 1, 8'h99, 2, 0, 4'b1011, 1, 4'b0100, 32'hA39977A0);
    add(0, 1, 8'h3C, 0, 1, 4'b1011, 0, 4'b0100, 32'hA39977A0);
    add(0, 1, 8'h3C, 0, 1, 4'b1111, 1, 4'b1111, 32'h3C3C3C3C);
    add(0, 0, 8'h00, 0, 0, 4'b0000, 0, 4'b1111, 32'h3C3C3C3C);
    add(0, 0, 8'h00, 3, 0, 4'b0000, 0, 4'b1111, 32'h3C3C3C3C);
    // keep slots 0 and 3, then reset with a handshake pending
    add(0, 0, 8'h00, 0, 0, 4'b0110, 0, 4'b1001, 32'h3C3C3C3C);
    add(1, 1, 8'hEE, 1, 0, 4'b0000, 1, 4'b0000, 32'h00000000);
    add(0, 0, 8'h00, 0, 0, 4'b0000, 1, 4'b0000, 32'h00000000);

    foreach (vq[k]) begin
      rst4 = vq[k].rst; vld4 = vq[k].vld; data4 = vq[k].data;
      sel4 = vq[k].sel; bc4 = vq[k].bc;   ordy4 = vq[k].ordy;
      #1;
      chk($sformatf("v%0d_rdy", k), 64'(rdy4), 64'(vq[k].e_rdy));
      tick();
      chk($sformatf("v%0d_ov", k), 64'(ov4), 64'(vq[k].e_ov));
      chk($sformatf("v%0d_od", k), 64'(od4), 64'(vq[k].e_od));
      chk($sformatf("v%0d_dp", k), 64'(dp4), 64'(vq[k].e_dp));
      chk($sformatf("v%0d_cnt", k), 64'(cnt4), 64'(vq[k].e_cnt));
    end
    rst4 = 1'b0; vld4 = 1'b0;

    // N_OUT=3: park a word in slot 0, then drop three out-of-range words
    drive3(1, 8'h11, 0, 0, 3'b000);
    #1;
    chk("n3_load_rdy", 64'(rdy3), 64'h1);
    tick();
    chk("n3_load_ov", 64'(ov3), 64'h1);
    chk("n3_load_od", 64'(od3), 64'h000011);
    drive3(1, 8'h5A, 3, 0, 3'b000);
    #1;
    chk("n3_oor_rdy", 64'(rdy3), 64'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("n3_drop%0d_dp", i), 64'(dp3), 64'h1);
      chk($sformatf("n3_drop%0d_cnt", i), 64'(cnt3), 64'(i));
      chk($sformatf("n3_drop%0d_ov", i), 64'(ov3), 64'h1);
    end
    drive3(0, 8'h00, 0, 0, 3'b000);
    tick();
    chk("n3_idle_dp", 64'(dp3), 64'h0);
    chk("n3_idle_cnt", 64'(cnt3), 64'h3);
    chk("n3_idle_od", 64'(od3), 64'h000011);

    // broadcast ignores an out-of-range select
    drive3(1, 8'h22, 3, 1, 3'b111);
    #1;
    chk("n3_bc_rdy", 64'(rdy3), 64'h1);
    tick();
    chk("n3_bc_ov", 64'(ov3), 64'h7);
    chk("n3_bc_od", 64'(od3), 64'h222222);
    chk("n3_bc_dp", 64'(dp3), 64'h0);
    chk("n3_bc_cnt", 64'(cnt3), 64'h3);

    // counter saturation
    drive3(1, 8'h5A, 3, 0, 3'b111);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 250) chk("n3_sat_254", 64'(cnt3), 64'd254);
      if (i == 251) chk("n3_sat_255", 64'(cnt3), 64'd255);
    end
    chk("n3_sat_cnt", 64'(cnt3), 64'd255);
    chk("n3_sat_dp", 64'(dp3), 64'h1);
    chk("n3_sat_ov", 64'(ov3), 64'h0);

    // reset clears the counter
    rst3 = 1'b1;
    drive3(1, 8'h44, 0, 0, 3'b000);
    tick();
    rst3 = 1'b0;
    drive3(0, 8'h00, 0, 0, 3'b000);
    chk("n3_rst_cnt", 64'(cnt3), 64'h0);
    chk("n3_rst_dp", 64'(dp3), 64'h0);
    chk("n3_rst_ov", 64'(ov3), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
Parametrised 1-to-N stream demultiplexer, the registered successor to the 4-way combinational demux. Routes one input word per cycle to the output channel chosen by `sel`, using valid/ready handshakes. Each output has a one-entry register slot, so a stalled channel does not block traffic to other channels. Adds a broadcast mode, out-of-range select detection and a saturating drop counter. Sits between a single producer and N independent consumers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
N_OUT, 4, number of output channels (2..16)
SEL_W, $clog2(N_OUT), select width, derived; not overridden
DROP_W, 8, drop counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input word valid
in_ready  out  1  block can accept the input word this cycle
in_data  in  WIDTH  input word
sel  in  SEL_W  destination channel, sampled only on acceptance
bcast  in  1  1 = deliver to all channels, sampled only on acceptance
out_valid  out  N_OUT  per-channel slot holds a word
out_ready  in  N_OUT  per-channel consumer accepts
out_data  out  N_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
drop_pulse  out  1  one-cycle pulse the cycle after an out-of-range word is dropped
drop_cnt  out  DROP_W  saturating count of dropped words

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high: `rst` is sampled only on a rising edge of `clk`.
- Reset values: out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0. in_ready is combinational and evaluates to 1 when all slots are empty.
- Slot i can load when `free[i] = !out_valid[i] || out_ready[i]`. Same-cycle drain-and-refill is allowed, giving full throughput.
- in_ready:
  - bcast=1: AND of free[i] over all i.
  - bcast=0 and sel<N_OUT: free[sel].
  - bcast=0 and sel>=N_OUT: 1.
- Combinational paths: in_ready depends combinationally on out_ready, sel and bcast. No combinational path from in_valid to in_ready.
- Accept: in_valid && in_ready at a rising edge.
  - Target slot(s) load in_data and set out_valid on that edge, so the word is visible the next cycle (latency 1).
  - Broadcast loads all N slots on the same edge with the identical word.
- Drain: out_valid[i] && out_ready[i] clears out_valid[i] unless the slot is refilled on the same edge. On refill, out_valid stays 1 and the data is replaced.
- out_data[i] holds its last value when the slot is empty; it is not cleared.
- Out-of-range select (only possible when N_OUT is not a power of two), bcast=0, accepted:
  - the word is discarded;
  - drop_pulse=1 for exactly the following cycle;
  - drop_cnt increments and saturates at 2^DROP_W-1.
- Simultaneous events: a drop and drains on other channels in the same cycle are independent. bcast=1 ignores sel, so no drop occurs.
- Ordering: words to one channel leave in acceptance order. No ordering is guaranteed across channels.
- Reset mid-operation: all slot contents are discarded (out_valid=0 on the next cycle) and drop_cnt returns to 0. An input handshake coinciding with an asserted rst is ignored.
- A producer must hold in_data, sel and bcast stable while in_valid=1 and in_ready=0. The block does not check this.
- No state machine beyond the per-slot full flag.

Decomposition:
- Package `stream_demux_pkg`: default WIDTH/N_OUT/DROP_W constants and a clog2 helper function.
- Sub-module `demux_slot`: one-entry register (WIDTH param) with ports load, in_data, out_valid, out_ready, out_data and free. Instantiate it N_OUT times in a generate loop.
- The top level holds select decode, in_ready logic and drop logic.

Test Plan:
1. After rst=1 for 2 cycles then release: out_valid=4'b0000, drop_cnt=0, in_ready=1.
2. N_OUT=4, all out_ready=1; send 0xA0,0xA1,0xA2,0xA3 with sel=0,1,2,3 back-to-back -> out_valid pulses one-hot one cycle after each, out_data[i]=0xA0+i, in_ready stays 1.
3. out_ready[2]=0; send 0x55 sel=2, then 0x66 sel=2 -> second word stalls (in_ready=0). Meanwhile send 0x77 sel=1, which is accepted. Raise out_ready[2] -> 0x66 loads in the same cycle 0x55 drains.
4. bcast=1, in_data=0x3C, out_ready=4'b1011 with slot 2 full -> in_ready=0. Release out_ready[2] -> all four channels show 0x3C on the next cycle.
5. N_OUT=3: send sel=3 three times -> three drop_pulse cycles, drop_cnt=3, no out_valid. Repeat 300 times with DROP_W=8 -> drop_cnt=255.
6. Slots 0 and 3 full, assert rst for one cycle with in_valid=1 -> next cycle out_valid=0, drop_cnt=0, and the input word does not appear on any channel.
